// File: rtl/lsu_mem_interface.sv
// rtl/lsu_mem_interface.sv - load/store unit bridging execute stage and L1 data-cache req/gnt/rvalid port
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the bus and pulse misalign_o instead.
module lsu_mem_interface #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_rd_en,
  input  logic              ex_wr_en,
  input  logic [2:0]        ex_mask,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  output logic              stall_o,
  output logic              ld_valid_o,
  output logic [31:0]       ld_data_o,
  output logic              bus_err_o,
  output logic              misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // One spare count so the counter can saturate past TIMEOUT-1 while in WAIT.
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       mask_q;
  logic [1:0]       off_q;
  logic             err_q;
  logic             mis_q;
  logic             op;
  logic             trap;
  logic             timeout_hit;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [31:0]      fmt_c;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;

  assign op = ex_rd_en | ex_wr_en;

`ifdef MISALIGN_TRAP_EN
  assign trap = ((ex_mask[1:0] == 2'b01) && ex_addr[0]) ||
                (ex_mask[1] && (ex_addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT != 0) && (cnt >= CNT_W'(TIMEOUT - 1));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = ex_wdata;
    case (ex_mask[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ex_addr[1:0];
        wdata_c = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = ex_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{ex_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = ex_wdata;
      end
    endcase
  end

  always_comb begin
    lane_b = mem_rdata_i[7:0];
    case (off_q)
      2'd0: lane_b = mem_rdata_i[7:0];
      2'd1: lane_b = mem_rdata_i[15:8];
      2'd2: lane_b = mem_rdata_i[23:16];
      2'd3: lane_b = mem_rdata_i[31:24];
      default: lane_b = mem_rdata_i[7:0];
    endcase
    lane_h = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (mask_q[1:0])
      2'b00:   fmt_c = {{24{~mask_q[2] & lane_b[7]}}, lane_b};
      2'b01:   fmt_c = {{16{~mask_q[2] & lane_h[15]}}, lane_h};
      default: fmt_c = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        stall_o = op;
        if (op) state_nxt = trap ? DONE : REQ;
      end
      REQ: begin
        stall_o = 1'b1;
        if (mem_gnt_i)        state_nxt = mem_we_o ? DONE : WAIT;
        else if (timeout_hit) state_nxt = DONE;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i || timeout_hit) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      mask_q      <= '0;
      off_q       <= '0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
      ld_data_o   <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (op) begin
            cnt         <= '0;
            mask_q      <= ex_mask;
            off_q       <= ex_addr[1:0];
            err_q       <= 1'b0;
            mis_q       <= trap;
            mem_we_o    <= ex_wr_en;
            mem_addr_o  <= {ex_addr[ADDR_W-1:2], 2'b00};
            mem_be_o    <= be_c;
            mem_wdata_o <= wdata_c;
          end
        end
        REQ: begin
          if (!(&cnt)) cnt <= cnt + 1'b1;
          if (!mem_gnt_i && timeout_hit) begin
            err_q     <= 1'b1;
            ld_data_o <= '0;
          end
        end
        WAIT: begin
          if (!(&cnt)) cnt <= cnt + 1'b1;
          if (mem_rvalid_i) begin
            ld_data_o <= fmt_c;
          end else if (timeout_hit) begin
            err_q     <= 1'b1;
            ld_data_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_o  = (state == REQ);
  assign ld_valid_o = (state == DONE) && !mem_we_o && !err_q && !mis_q;
  assign bus_err_o  = (state == DONE) && err_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_o = (state == DONE) && mis_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_interface.sv
// tb/tb_lsu_mem_interface.sv - directed self-checking bench for lsu_mem_interface with an access-level model
module tb_lsu_mem_interface;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_rd_en, ex_wr_en;
  logic [2:0]  ex_mask;
  logic [31:0] ex_addr, ex_wdata;
  logic        stall_o, ld_valid_o, bus_err_o, misalign_o;
  logic [31:0] ld_data_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  lsu_mem_interface #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .ex_rd_en(ex_rd_en), .ex_wr_en(ex_wr_en), .ex_mask(ex_mask),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .stall_o(stall_o), .ld_valid_o(ld_valid_o), .ld_data_o(ld_data_o),
    .bus_err_o(bus_err_o), .misalign_o(misalign_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Access size in bytes and the naturally aligned lane offset that the bus sees.
  function automatic int m_size(input logic [2:0] m);
    return m[1] ? 4 : (m[0] ? 2 : 1);
  endfunction

  function automatic int m_off(input logic [2:0] m, input logic [31:0] a);
    int n;
    n = m_size(m);
    return (int'(a[1:0]) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] m, input logic [31:0] a);
    int n;
    n = m_size(m);
    return 4'(((1 << n) - 1) << m_off(m, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] m, input logic [31:0] d);
    int n;
    n = m_size(m);
    if (n == 1) return {24'h0, d[7:0]} * 32'h01010101;
    if (n == 2) return {16'h0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] m, input logic [31:0] a, input logic [31:0] r);
    int n, bits;
    logic [31:0] lane, msk;
    n = m_size(m);
    if (n == 4) return r;
    bits = 8 * n;
    msk  = (32'h1 << bits) - 32'h1;
    lane = (r >> (8 * m_off(m, a))) & msk;
    if (!m[2] && lane[bits-1]) lane = lane | ~msk;
    return lane;
  endfunction

  function automatic logic m_mis(input logic [2:0] m, input logic [31:0] a);
    int n;
    n = m_size(m);
    return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
  endfunction

  // Current transaction as seen by the compare process.
  logic [31:0] cur_addr, cur_wdata, cur_ld;
  logic [3:0]  cur_be;
  logic        cur_we;

  logic [31:0] last_ld, last_wdata;
  logic [3:0]  last_be;

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (mem_req_o) begin
        chk("req_addr", mem_addr_o, cur_addr);
        chk("req_be", {28'h0, mem_be_o}, {28'h0, cur_be});
        chk("req_we", {31'h0, mem_we_o}, {31'h0, cur_we});
        chk("req_wdata", mem_wdata_o, cur_wdata);
      end
      if (ld_valid_o) begin
        chk("ld_data", ld_data_o, cur_ld);
        chk("ld_on_load", {31'h0, cur_we}, 32'h0);
      end
    end
  end

  // gnt_delay < 0 means the grant never comes.
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] d, input int gnt_delay,
                        input logic [31:0] rdata);
    bit trap, tmo, rv_pending, done;
    int exp_stall, exp_req, stall_n, req_n, lv_n, err_n, mis_n;
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = m_mis(m, a);
`endif
    tmo = !trap && (gnt_delay < 0 || gnt_delay > TMO - 1);
    exp_stall = trap ? 1 : (tmo ? 1 + TMO : gnt_delay + (wr ? 2 : 3));
    exp_req   = trap ? 0 : (tmo ? TMO : gnt_delay + 1);
    cur_addr  = {a[31:2], 2'b00};
    cur_be    = m_be(m, a);
    cur_we    = wr;
    cur_wdata = wr ? m_wdata(m, d) : d;
    cur_ld    = m_ld(m, a, rdata);
    stall_n = 0; req_n = 0; lv_n = 0; err_n = 0; mis_n = 0;
    rv_pending = 1'b0; done = 1'b0;
    @(negedge clk);
    ex_rd_en = rd; ex_wr_en = wr; ex_mask = m; ex_addr = a; ex_wdata = d;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      mem_rvalid_i = rv_pending;
      mem_rdata_i  = rv_pending ? rdata : 32'h0BAD0BAD;
      rv_pending   = 1'b0;
      mem_gnt_i    = 1'b0;
      lv_n  += int'(ld_valid_o);
      err_n += int'(bus_err_o);
      mis_n += int'(misalign_o);
      if (mem_req_o) begin
        req_n++;
        last_be    = mem_be_o;
        last_wdata = mem_wdata_o;
        if (gnt_delay >= 0 && req_n - 1 == gnt_delay) begin
          mem_gnt_i  = 1'b1;
          rv_pending = !wr;
        end
      end
      if (stall_o) begin
        stall_n++;
      end else begin
        done = 1'b1;
        last_ld = ld_data_o;
        ex_rd_en = 1'b0; ex_wr_en = 1'b0;
        chk({tag, "_bus_err"}, {31'h0, bus_err_o}, {31'h0, tmo});
        chk({tag, "_misalign"}, {31'h0, misalign_o}, {31'h0, trap});
        if (!wr && !trap) chk({tag, "_ld_data_done"}, ld_data_o, tmo ? 32'h0 : cur_ld);
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      chk({tag, "_completion_bound"}, 32'h0, 32'h1);
      ex_rd_en = 1'b0; ex_wr_en = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    end
    chk({tag, "_stall_cycles"}, stall_n, exp_stall);
    chk({tag, "_req_cycles"}, req_n, exp_req);
    chk({tag, "_ld_pulses"}, lv_n, (!wr && !tmo && !trap) ? 1 : 0);
    chk({tag, "_err_pulses"}, err_n, tmo ? 1 : 0);
    chk({tag, "_mis_pulses"}, mis_n, trap ? 1 : 0);
    @(negedge clk);
    #1;
    chk({tag, "_idle_stall"}, {31'h0, stall_o}, 32'h0);
    chk({tag, "_idle_pulses"}, {29'h0, ld_valid_o, bus_err_o, misalign_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ex_rd_en = 0; ex_wr_en = 0; ex_mask = 0; ex_addr = 0; ex_wdata = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    cur_addr = 0; cur_wdata = 0; cur_ld = 0; cur_be = 0; cur_we = 0;
    last_ld = 0; last_wdata = 0; last_be = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl", {28'h0, stall_o, ld_valid_o, bus_err_o, misalign_o}, 32'h0);
    chk("rst_req", {30'h0, mem_req_o, mem_we_o}, 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_be", {28'h0, mem_be_o}, 32'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);
    chk("rst_ld_data", ld_data_o, 32'h0);
    reset = 1'b0;

    run_op("lw", 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    chk("lw_lit_data", last_ld, 32'hDEADBEEF);
    chk("lw_lit_be", {28'h0, last_be}, 32'hF);

    run_op("lb", 1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233);
    chk("lb_lit_data", last_ld, 32'hFFFFFF80);
    chk("lb_lit_be", {28'h0, last_be}, 32'h8);
    run_op("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80112233);
    chk("lbu_lit_data", last_ld, 32'h00000080);

    run_op("sh", 0, 1, 3'b001, 32'h206, 32'h0000ABCD, 4, 32'h0);
    chk("sh_lit_be", {28'h0, last_be}, 32'hC);
    chk("sh_lit_wdata", last_wdata, 32'hABCDABCD);

    run_op("sb_both", 1, 1, 3'b000, 32'h1, 32'h1234565A, 1, 32'h0);
    chk("sb_lit_be", {28'h0, last_be}, 32'h2);
    chk("sb_lit_wdata", last_wdata, 32'h5A5A5A5A);

    run_op("lh", 1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h80017FFF);
    chk("lh_lit_data", last_ld, 32'hFFFF8001);
    run_op("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 0, 32'h80018FFF);
    chk("lhu_lit_data", last_ld, 32'h00008FFF);
    run_op("lb1", 1, 0, 3'b000, 32'h101, 32'h0, 0, 32'h1234C356);
    chk("lb1_lit_data", last_ld, 32'hFFFFFFC3);
    run_op("lbu2", 1, 0, 3'b100, 32'h102, 32'h0, 0, 32'h1234C356);
    chk("lbu2_lit_data", last_ld, 32'h00000034);

    run_op("lw_tmo", 1, 0, 3'b010, 32'h300, 32'h0, -1, 32'h0);
    chk("tmo_lit_data", last_ld, 32'h0);

    run_op("sw_gnt_last", 0, 1, 3'b010, 32'h40, 32'hCAFEF00D, TMO - 1, 32'h0);
    chk("sw_lit_wdata", last_wdata, 32'hCAFEF00D);

    run_op("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h13579BDF);
`ifndef MISALIGN_TRAP_EN
    chk("lw_mis_lit_data", last_ld, 32'h13579BDF);
`endif

    // Reset while waiting for read data, then a stray rvalid.
    @(negedge clk);
    ex_rd_en = 1; ex_wr_en = 0; ex_mask = 3'b010; ex_addr = 32'h500;
    cur_addr = 32'h500; cur_be = 4'hF; cur_we = 1'b0; cur_wdata = 32'h0; cur_ld = 32'h0;
    @(negedge clk);
    #1;
    chk("rstw_req", {31'h0, mem_req_o}, 32'h1);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    #1;
    mem_gnt_i = 1'b0;
    ex_rd_en = 1'b0;
    chk("rstw_wait_stall", {31'h0, stall_o}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h55AA55AA;
    chk("rstw_idle", {30'h0, stall_o, mem_req_o}, 32'h0);
    @(negedge clk);
    #1;
    mem_rvalid_i = 1'b0;
    chk("rstw_no_ld", {29'h0, ld_valid_o, stall_o, mem_req_o}, 32'h0);
    @(negedge clk);
    #1;
    chk("rstw_still_idle", {29'h0, ld_valid_o, stall_o, bus_err_o}, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_interface.md
Name: lsu_mem_interface

Overview:
- Load/store unit between the core's execute stage and the L1 data-cache port of each core in the multicore system.
- Consumes controller outputs rd_en, wr_en and mask (func3), plus the ALU-computed address and rs2 data.
- Issues word-aligned byte-enabled requests over a req/gnt/rvalid handshake and stalls the core until the access completes.
- Returns aligned, sign- or zero-extended load data for writeback.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT, 64, max cycles spent in REQ+WAIT before bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- ex_rd_en  in  1  load request from controller
- ex_wr_en  in  1  store request; dominates ex_rd_en
- ex_mask  in  3  func3 access size/sign
- ex_addr  in  ADDR_W  byte address
- ex_wdata  in  32  store data (rs2)
- stall_o  out  1  hold PC and pipeline
- ld_valid_o  out  1  load data valid, one-cycle pulse
- ld_data_o  out  32  formatted load data
- bus_err_o  out  1  timeout, one-cycle pulse
- misalign_o  out  1  misaligned access flag
- mem_req_o  out  1  request
- mem_we_o  out  1  write
- mem_addr_o  out  ADDR_W  word address, [1:0]=0
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated store data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - State goes to IDLE; all outputs go to 0; timeout counter goes to 0.
  - Reset mid-operation aborts at the next edge; mem_req_o drops.
  - mem_rvalid_i arriving outside WAIT is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - op = ex_rd_en | ex_wr_en.
  - If op: capture addr, mask, wdata and we = ex_wr_en; go to REQ.
  - stall_o = op, combinational.
- REQ:
  - mem_req_o=1 with registered mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o; these are held stable until gnt.
  - On gnt with a store: go to DONE.
  - On gnt with a load: go to WAIT.
- WAIT: on mem_rvalid_i, register the formatted data into ld_data_o and go to DONE. rvalid in the same cycle as gnt is illegal on this port.
- DONE:
  - Exactly one cycle; stall_o=0; ld_valid_o=1 for loads only.
  - ex_* inputs are ignored (the core still presents the same instruction). Go to IDLE.
- stall_o=1 in REQ and WAIT.
- Minimum load latency: issue cycle in IDLE, REQ with gnt, WAIT with rvalid, then DONE. The core commits 3 cycles after first presentation.
- Minimum store latency: issue cycle, REQ with gnt, then DONE.
- Byte enables, with off = addr[1:0]:
  - mask[1:0]=00 (byte): be = 1<<off; wdata = {4{b}}.
  - mask[1:0]=01 (half): be = addr[1] ? 1100 : 0011; wdata = {2{h}}.
  - mask[1:0]=10 or 11 (word): be = 1111.
- Load format:
  - Select the byte/half lane by offset.
  - mask[2]=0: sign-extend; mask[2]=1: zero-extend.
  - Word loads pass through.
- Timeout:
  - Counter increments each cycle in REQ/WAIT and clears on entering REQ.
  - When count == TIMEOUT-1 without completion: go to DONE with bus_err_o=1, ld_valid_o=0, ld_data_o=0, and mem_req_o dropped.
- Misalignment: a half-word access with addr[0]=1, or a word access with addr[1:0]≠0.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - A misaligned op goes from IDLE straight to DONE; there is no memory traffic.
  - misalign_o=1 for the DONE cycle; ld_valid_o=0.
- Undefined:
  - misalign_o is tied 0.
  - Address LSBs below the access size are ignored: half uses addr[1] only, word uses the word address.

Test Plan:
- LW addr 0x100, gnt at first REQ cycle, rvalid next cycle with 0xDEADBEEF → mem_be_o=1111, mem_addr_o=0x100, ld_data_o=0xDEADBEEF, stall_o high 3 cycles.
- LB addr 0x103, rdata 0x80112233 → mem_be_o=1000, ld_data_o=0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x206, ex_wdata 0x0000ABCD, gnt delayed 4 cycles → mem_we_o=1, be=1100, wdata=0xABCDABCD, req held 5 cycles, no ld_valid_o.
- ex_rd_en=ex_wr_en=1 (store encoding), SB addr 0x1 data 0x5A → store issued, be=0010, wdata=0x5A5A5A5A.
- TIMEOUT=8, LW with gnt never asserted → bus_err_o pulse after 8 REQ cycles, stall_o released, ld_data_o=0.
- LW addr 0x102 with MISALIGN_TRAP_EN → no mem_req_o, misalign_o pulse; without the macro → mem_addr_o=0x100, normal load.
- Reset asserted in WAIT, then rvalid → back to IDLE, rvalid ignored, ld_valid_o stays 0.
